// File: rtl/bsg_manycore_trace_pkg.sv
// rtl/bsg_manycore_trace_pkg.sv - trace record layout, cache opcodes and opcode classification
`ifndef BSG_MANYCORE_TRACE_PKG_SV
`define BSG_MANYCORE_TRACE_PKG_SV

`define DECLARE_BSG_MANYCORE_TRACE_REC_S(addr_w, data_w, ts_w, chan_w) \
   typedef struct packed { \
      logic [ts_w-1:0]   timestamp; \
      logic [chan_w-1:0] chan_id; \
      logic [5:0]        opcode; \
      logic [addr_w-1:0] addr; \
      logic [data_w-1:0] data; \
   } bsg_manycore_trace_rec_s

package bsg_manycore_trace_pkg;

   localparam int trace_opcode_width = 6;

   // Encodings follow the vcache packet opcode map.
   localparam logic [5:0] LB  = 6'b000000;
   localparam logic [5:0] LH  = 6'b000001;
   localparam logic [5:0] LW  = 6'b000010;
   localparam logic [5:0] LD  = 6'b000011;
   localparam logic [5:0] LBU = 6'b000100;
   localparam logic [5:0] LHU = 6'b000101;
   localparam logic [5:0] LWU = 6'b000110;
   localparam logic [5:0] SB  = 6'b001000;
   localparam logic [5:0] SH  = 6'b001001;
   localparam logic [5:0] SW  = 6'b001010;
   localparam logic [5:0] SD  = 6'b001011;
   localparam logic [5:0] LM  = 6'b001100;
   localparam logic [5:0] SM  = 6'b001101;

   typedef enum logic [1:0] {
      e_trace_load  = 2'd0,
      e_trace_store = 2'd1,
      e_trace_other = 2'd2
   } trace_class_e;

   function automatic trace_class_e opcode_class(input logic [5:0] op);
      case (op)
         LB, LH, LW, LD, LBU, LHU, LWU, LM: opcode_class = e_trace_load;
         SB, SH, SW, SD, SM:                opcode_class = e_trace_store;
         default:                           opcode_class = e_trace_other;
      endcase
   endfunction

endpackage

`endif

// File: rtl/bsg_manycore_vcache_trace_buffer_mem.sv
// rtl/bsg_manycore_vcache_trace_buffer_mem.sv - 1r1w record storage, synchronous write, combinational read
module bsg_manycore_vcache_trace_buffer_mem
#(parameter int width_p = 8,
  parameter int els_p = 4,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_w = $clog2(els_p))
(
   input  logic               clk,
   input  logic               w_v,
   input  logic [addr_w-1:0]  w_addr,
   input  logic [width_p-1:0] w_data,
   input  logic [addr_w-1:0]  r_addr,
   output logic [width_p-1:0] r_data
);

   logic [width_p-1:0] mem [els_p];

   always_ff @(posedge clk) begin
      if (w_v) mem[w_addr] <= w_data;
   end

   if (read_write_same_addr_p != 0) begin : g_bypass
      assign r_data = (w_v && (w_addr == r_addr)) ? w_data : mem[r_addr];
   end else begin : g_direct
      assign r_data = mem[r_addr];
   end

endmodule

// File: rtl/bsg_manycore_vcache_trace_buffer.sv
// rtl/bsg_manycore_vcache_trace_buffer.sv - filtered, timestamped capture of vcache packet handshakes into a circular buffer
module bsg_manycore_vcache_trace_buffer
   import bsg_manycore_trace_pkg::*;
#(parameter int num_chan_p = 4,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int els_p = 64,
  parameter int timestamp_width_p = 32,
  parameter int drop_width_p = 16,
  localparam int chan_w = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int ptr_w = $clog2(els_p),
  localparam int mask_w = data_width_p / 8,
  localparam int pkt_width_lp = trace_opcode_width + addr_width_p + data_width_p + mask_w,
  localparam int rec_width_lp = timestamp_width_p + chan_w + trace_opcode_width + addr_width_p + data_width_p)
(
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             trace_en_i,
   input  logic                             clear_i,
   input  logic                             wrap_mode_i,
   input  logic [2:0]                       filter_i,
   input  logic [num_chan_p*pkt_width_lp-1:0] cache_pkt_i,
   input  logic [num_chan_p-1:0]            v_i,
   input  logic [num_chan_p-1:0]            ready_i,
   output logic                             rec_v_o,
   output logic [rec_width_lp-1:0]          rec_o,
   input  logic                             rec_yumi_i,
   output logic [ptr_w:0]                   count_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [drop_width_p-1:0]          drop_count_o,
   output logic                             overflow_o
);

   localparam int inc_w = $clog2(num_chan_p + 1);
   localparam int data_lsb = mask_w;
   localparam int addr_lsb = data_lsb + data_width_p;
   localparam int op_lsb = addr_lsb + addr_width_p;

   `DECLARE_BSG_MANYCORE_TRACE_REC_S(addr_width_p, data_width_p, timestamp_width_p, chan_w);

   logic [timestamp_width_p-1:0] ts;
   logic [ptr_w-1:0]             wptr, rptr;
   logic [ptr_w:0]               count;
   logic [drop_width_p-1:0]      drop;
   logic                         ovf;

   // Lowest qualified channel wins; the rest are counted as drops.
   logic [num_chan_p-1:0] qual;
   logic [chan_w-1:0]     sel;
   logic [inc_w-1:0]      nqual;
   always_comb begin
      qual  = '0;
      sel   = '0;
      nqual = '0;
      for (int c = num_chan_p - 1; c >= 0; c--) begin
         if (v_i[c] & ready_i[c] & trace_en_i
             & filter_i[opcode_class(cache_pkt_i[c*pkt_width_lp + op_lsb +: trace_opcode_width])]) begin
            qual[c] = 1'b1;
            sel     = chan_w'(c);
            nqual   = nqual + inc_w'(1);
         end
      end
   end

   logic [pkt_width_lp-1:0] pkt_sel;
   assign pkt_sel = cache_pkt_i[int'(sel)*pkt_width_lp +: pkt_width_lp];

   logic unused_mask;
   assign unused_mask = ^pkt_sel[mask_w-1:0];

   bsg_manycore_trace_rec_s wrec;
   assign wrec.timestamp = ts;
   assign wrec.chan_id   = sel;
   assign wrec.opcode    = pkt_sel[op_lsb +: trace_opcode_width];
   assign wrec.addr      = pkt_sel[addr_lsb +: addr_width_p];
   assign wrec.data      = pkt_sel[data_lsb +: data_width_p];

   logic push, full, pop, wen, overwrite, stop_drop, grow;
   assign push      = |qual;
   assign full      = (count == (ptr_w+1)'(els_p));
   assign pop       = rec_yumi_i & (count != '0);
   assign wen       = push & ~clear_i & (~full | pop | wrap_mode_i);
   assign overwrite = push & full & ~pop & wrap_mode_i;
   assign stop_drop = push & full & ~pop & ~wrap_mode_i;
   // A full-buffer overwrite writes a slot but leaves occupancy unchanged.
   assign grow      = wen & ~(full & ~pop);

   logic [inc_w-1:0]              inc;
   logic [drop_width_p+inc_w-1:0] drop_sum;
   logic [drop_width_p-1:0]       drop_next;
   assign inc       = nqual - inc_w'(push) + inc_w'(stop_drop);
   assign drop_sum  = {inc_w'(0), drop} + (drop_width_p+inc_w)'(inc);
   assign drop_next = (|drop_sum[drop_width_p+inc_w-1 -: inc_w]) ? '1 : drop_sum[drop_width_p-1:0];

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ts    <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         drop  <= '0;
         ovf   <= 1'b0;
      end else begin
         ts <= ts + timestamp_width_p'(1);
         if (clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            drop  <= '0;
            ovf   <= 1'b0;
         end else begin
            if (wen) wptr <= wptr + ptr_w'(1);
            if (pop | overwrite) rptr <= rptr + ptr_w'(1);
            count <= count + (ptr_w+1)'(grow) - (ptr_w+1)'(pop);
            drop  <= drop_next;
            if ((inc != '0) | overwrite) ovf <= 1'b1;
         end
      end
   end

   bsg_manycore_vcache_trace_buffer_mem #(
      .width_p(rec_width_lp),
      .els_p(els_p),
      .read_write_same_addr_p(0)
   ) mem (
      .clk(clk_i),
      .w_v(wen),
      .w_addr(wptr),
      .w_data(wrec),
      .r_addr(rptr),
      .r_data(rec_o)
   );

   assign count_o      = count;
   assign full_o       = full;
   assign empty_o      = (count == '0);
   assign rec_v_o      = (count != '0);
   assign drop_count_o = drop;
   assign overflow_o   = ovf;

endmodule

// File: tb/tb_bsg_manycore_vcache_trace_buffer.sv
// tb/tb_bsg_manycore_vcache_trace_buffer.sv - directed and randomized checks against a queue-based capture model
module tb_bsg_manycore_vcache_trace_buffer;

   localparam int NCH = 4, AW = 28, DW = 32, ELS = 4, TSW = 32, DRW = 4;
   localparam int MW = DW / 8, PW = 6 + AW + DW + MW, CW = 2, RW = TSW + CW + 6 + AW + DW;
   localparam int DMAX = (1 << DRW) - 1;

   localparam logic [5:0] LB = 6'd0, LH = 6'd1, LW = 6'd2, LD = 6'd3, LBU = 6'd4, LHU = 6'd5, LWU = 6'd6;
   localparam logic [5:0] LDU = 6'd7, SB = 6'd8, SH = 6'd9, SW = 6'd10, SD = 6'd11, LM = 6'd12, SM = 6'd13;
   localparam logic [5:0] TAGST = 6'd16, AFL = 6'd20, AMOSWAP = 6'h20;

   logic [5:0] optab [16] = '{LB, LH, LW, LD, LBU, LHU, LWU, LM, SB, SH, SW, SD, SM, LDU, TAGST, AMOSWAP};

   logic clk = 1'b0, reset = 1'b1;
   logic en, clr, wrap, yumi;
   logic [2:0] filter;
   logic [NCH-1:0] v, rdy;
   logic [5:0]    op [NCH];
   logic [AW-1:0] ad [NCH];
   logic [DW-1:0] dt [NCH];
   logic [MW-1:0] mk [NCH];
   logic [NCH*PW-1:0] pkt;

   logic rec_v, full, empty, ovf;
   logic [RW-1:0] rec;
   logic [$clog2(ELS):0] count;
   logic [DRW-1:0] drop;

   logic [RW-1:0]  mq [$];
   int             mdrop;
   logic           movf;
   logic [TSW-1:0] mts;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   always_comb begin
      pkt = '0;
      for (int c = 0; c < NCH; c++) pkt[c*PW +: PW] = {op[c], ad[c], dt[c], mk[c]};
   end

   bsg_manycore_vcache_trace_buffer #(
      .num_chan_p(NCH), .addr_width_p(AW), .data_width_p(DW),
      .els_p(ELS), .timestamp_width_p(TSW), .drop_width_p(DRW)
   ) dut (
      .clk_i(clk), .reset_i(reset), .trace_en_i(en), .clear_i(clr),
      .wrap_mode_i(wrap), .filter_i(filter), .cache_pkt_i(pkt),
      .v_i(v), .ready_i(rdy), .rec_v_o(rec_v), .rec_o(rec),
      .rec_yumi_i(yumi), .count_o(count), .full_o(full), .empty_o(empty),
      .drop_count_o(drop), .overflow_o(ovf)
   );

   function automatic int op_class(input logic [5:0] o);
      if (o inside {LB, LH, LW, LD, LBU, LHU, LWU, LM}) return 0;
      if (o inside {SB, SH, SW, SD, SM}) return 1;
      return 2;
   endfunction

   function automatic logic [RW-1:0] mkrec(input logic [TSW-1:0] t, input int ch,
                                           input logic [5:0] o, input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
      return {t, CW'(ch), o, a, d};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      mdrop = 0;
      movf  = 1'b0;
      mts   = '0;
   endtask

   task automatic model_update();
      int n, first, extra;
      logic [RW-1:0] r;
      n = 0;
      first = -1;
      for (int c = 0; c < NCH; c++)
         if (v[c] && rdy[c] && en && filter[op_class(op[c])]) begin
            if (first < 0) first = c;
            n++;
         end
      if (clr) begin
         mq.delete();
         mdrop = 0;
         movf = 1'b0;
      end else begin
         if (yumi && mq.size() > 0) void'(mq.pop_front());
         if (n > 0) begin
            r = mkrec(mts, first, op[first], ad[first], dt[first]);
            extra = n - 1;
            if (mq.size() < ELS) mq.push_back(r);
            else if (wrap) begin
               void'(mq.pop_front());
               mq.push_back(r);
               movf = 1'b1;
            end else extra++;
            if (extra > 0) movf = 1'b1;
            mdrop = (mdrop + extra > DMAX) ? DMAX : mdrop + extra;
         end
      end
      mts = mts + 1'b1;
   endtask

   task automatic check_all();
      chk("rec_v", rec_v, mq.size() > 0);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == ELS);
      chk("empty", empty, mq.size() == 0);
      chk("drop_count", drop, mdrop);
      chk("overflow", ovf, movf);
      if (mq.size() > 0) chk("rec", rec, mq[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic idle();
      v = '0;
      rdy = '0;
      yumi = 1'b0;
      clr = 1'b0;
   endtask

   task automatic ev(input int c, input logic [5:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d);
      v[c] = 1'b1;
      rdy[c] = 1'b1;
      op[c] = o;
      ad[c] = a;
      dt[c] = d;
      mk[c] = MW'($urandom);
   endtask

   task automatic do_clear();
      idle();
      clr = 1'b1;
      tick();
   endtask

   initial begin
      en = 1'b1; clr = 1'b0; wrap = 1'b0; yumi = 1'b0; filter = 3'b111; v = '0; rdy = '0;
      for (int c = 0; c < NCH; c++) begin
         op[c] = LB; ad[c] = '0; dt[c] = '0; mk[c] = '0;
      end
      model_reset();
      #2 reset = 1'b0;
      #1 check_all();
      @(negedge clk) reset = 1'b1;

      // single event at timestamp 10
      while (mts != 10) begin
         idle();
         tick();
      end
      idle(); ev(2, SM, 28'h100, 32'hAB); tick();
      chk("single_rec", rec, mkrec(32'd10, 2, SM, 28'h100, 32'hAB));
      chk("single_count", count, 1);
      idle(); yumi = 1'b1; tick();
      chk("single_pop_empty", empty, 1);

      // filter: loads only
      filter = 3'b001;
      idle(); ev(0, SW, 28'h200, 32'd1); tick();
      idle(); ev(1, LW, 28'h204, 32'd2); tick();
      chk("filter_count", count, 1);
      chk("filter_op", rec[AW+DW +: 6], LW);
      chk("filter_drop", drop, 0);
      idle(); yumi = 1'b1; tick();

      // collision on channels 0, 1, 3
      filter = 3'b111;
      idle(); ev(0, LW, 28'h300, 32'd3); ev(1, SW, 28'h304, 32'd4); ev(3, TAGST, 28'h308, 32'd5); tick();
      chk("coll_chan", rec[6+AW+DW +: CW], 0);
      chk("coll_drop", drop, 2);
      chk("coll_ovf", ovf, 1);
      do_clear();
      chk("clear_drop", drop, 0);

      // stop mode: fifth event discarded
      wrap = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle(); ev(1, LD, AW'(i), 32'h1000 + i); tick();
      end
      chk("stop_count", count, 4);
      chk("stop_drop", drop, 1);
      for (int i = 0; i < 4; i++) begin
         chk("stop_order", rec[DW +: AW], i);
         idle(); yumi = 1'b1; tick();
      end
      chk("stop_drained", empty, 1);
      do_clear();

      // wrap mode: oldest two overwritten, then push+pop while full
      wrap = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(); ev(2, SD, AW'(i), 32'h2000 + i); tick();
      end
      chk("wrap_count", count, 4);
      chk("wrap_drop", drop, 0);
      chk("wrap_ovf", ovf, 1);
      chk("wrap_head", rec[DW +: AW], 2);
      idle(); yumi = 1'b1; ev(0, SB, 28'd6, 32'h2006); tick();
      chk("pushpop_count", count, 4);
      chk("pushpop_drop", drop, 0);
      for (int i = 3; i < 7; i++) begin
         chk("wrap_order", rec[DW +: AW], i);
         idle(); yumi = 1'b1; tick();
      end
      do_clear();
      wrap = 1'b0;

      // clear wins over a same-cycle event
      for (int i = 0; i < 3; i++) begin
         idle(); ev(3, LH, AW'(i), 32'd0); tick();
      end
      idle(); clr = 1'b1; ev(2, LW, 28'h50, 32'd0); tick();
      chk("clear_empty", empty, 1);
      chk("clear_event_drop", drop, 0);

      // drop counter saturation with clamped multi-increment
      for (int i = 0; i < 4; i++) begin
         idle(); ev(0, LW, AW'(i), 32'd0); tick();
      end
      for (int k = 0; k < 3; k++) begin
         idle(); for (int c = 0; c < NCH; c++) ev(c, LBU, 28'hAA, 32'd0); tick();
      end
      chk("drop_12", drop, 12);
      idle(); for (int c = 0; c < NCH; c++) ev(c, LBU, 28'hAA, 32'd0); tick();
      chk("drop_sat", drop, DMAX);
      do_clear();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         en = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) filter = 3'($urandom);
         if ($urandom_range(31) == 0) wrap = ~wrap;
         clr = ($urandom_range(40) == 0);
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(2) == 0) begin
               v[c] = 1'b1;
               rdy[c] = ($urandom_range(3) != 0);
               op[c] = optab[$urandom_range(15)];
               ad[c] = AW'($urandom);
               dt[c] = $urandom;
               mk[c] = MW'($urandom);
            end
         yumi = (mq.size() > 0) && ($urandom_range(1) == 1);
         tick();
      end

      // asynchronous reset mid-drain
      wrap = 1'b0; en = 1'b1; filter = 3'b111;
      do_clear();
      for (int i = 0; i < 3; i++) begin
         idle(); ev(1, LWU, AW'(i), 32'd7); tick();
      end
      idle(); ev(0, LW, 28'h9, 32'd9); ev(2, LW, 28'hA, 32'd9); tick();
      idle(); yumi = 1'b1; tick();
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      chk("rst_rec_v", rec_v, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk) reset = 1'b1;
      idle(); ev(0, SH, 28'h77, 32'd5); tick();
      chk("post_reset_ts", rec[RW-1 -: TSW], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_vcache_trace_buffer.md
# bsg_manycore_vcache_trace_buffer

Multi-channel, filterable capture buffer for vcache request traffic. It sits beside the `bsg_manycore_link_to_cache` instances and snoops each channel's cache-packet handshake. Every accepted packet that passes the opcode filter is stored as a timestamped record in a circular buffer. Host or testbench logic drains the buffer through a valid/yumi port, which lets .nbf minimization and access profiling run without file I/O in the simulation hot path.

## Interface
- num_chan_p, 4: number of snooped cache channels (≥1).
- addr_width_p, 28: cache packet address width.
- data_width_p, 32: cache packet data width.
- els_p, 64: buffer depth; must be a power of 2 and ≥2.
- timestamp_width_p, 32: free-running timestamp width.
- drop_width_p, 16: width of the drop counter.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low.
- trace_en_i  in  1  capture enable; readout is unaffected by it.
- clear_i  in  1  synchronous flush of the buffer, drop counter and overflow flag.
- wrap_mode_i  in  1  1 = overwrite oldest record when full; 0 = stop capturing when full.
- filter_i  in  3  class enables: [0] load, [1] store, [2] other.
- cache_pkt_i  in  num_chan_p*pkt_width  packed bsg_cache_pkt_s, one per channel; channel 0 in the LSBs.
- v_i  in  num_chan_p  per-channel packet valid.
- ready_i  in  num_chan_p  per-channel cache ready.
- rec_v_o  out  1  head record is valid.
- rec_o  out  rec_width  head record.
- rec_yumi_i  in  1  consume head; legal only when rec_v_o=1.
- count_o  out  log2(els_p)+1  number of occupied entries.
- full_o / empty_o  out  1  buffer full / buffer empty.
- drop_count_o  out  drop_width_p  count of lost events; saturates.
- overflow_o  out  1  sticky; set by any drop or overwrite.

## Operation
- Qualified event on channel c: v_i[c] & ready_i[c] & trace_en_i & filter_i[class(opcode)].
- Opcode classes:
  - load = LB, LH, LW, LD, LBU, LHU, LWU, LM.
  - store = SB, SH, SW, SD, SM.
  - other = every remaining opcode.
- Record fields, MSB to LSB: {timestamp, chan_id (log2 num_chan_p, min 1 bit), opcode, addr, data}. The timestamp is the counter value in the handshake cycle.
- Multiple qualified events in one cycle:
  - The lowest-index channel is captured.
  - Each of the other qualified events adds 1 to drop_count_o and sets overflow_o.
- Full buffer with a push and no pop:
  - wrap_mode_i=1: the record is written at wptr, rptr advances (oldest record lost), count_o is unchanged, overflow_o is set, drop_count_o is unchanged.
  - wrap_mode_i=0: the record is discarded, drop_count_o +1, overflow_o is set.
- Full buffer with push and pop in the same cycle: both take effect in either mode. count_o stays at els_p and no drop is recorded.
- Empty buffer with push and pop in the same cycle: impossible, because rec_v_o=0 and yumi is illegal.
- drop_count_o saturates at all ones. Several increments in one cycle are clamped.
- clear_i has priority over capture and pop in the same cycle:
  - Pointers, count, drop count and overflow go to 0.
  - That cycle's events are neither stored nor counted.
  - The timestamp is not cleared.
- The timestamp increments every cycle after reset, regardless of trace_en_i, and wraps modulo 2^timestamp_width_p.

## Timing
- Reset (reset_i=0, asynchronous) gives:
  - rec_v_o=0, full_o=0, empty_o=1, count_o=0.
  - drop_count_o=0, overflow_o=0, timestamp=0, pointers=0.
  - rec_o is don't-care.
- Capture latency: an event in cycle N is visible on rec_o/rec_v_o in cycle N+1 when the buffer was empty.
- rec_o is read combinationally at rptr. Pop takes effect at the clock edge.
- count_o, full_o, empty_o and drop_count_o are registered and update one edge after the causing event.
- Pointers are log2(els_p) bits and wrap naturally. full/empty come from count, not from pointer compare.
- Reset asserted mid-operation discards all contents immediately. There is no partial record.

## Structure
- Shared package `bsg_manycore_trace_pkg`:
  - class enum (load/store/other).
  - opcode-to-class function built on bsg_cache_pkg opcodes.
  - `declare_bsg_manycore_trace_rec_s` macro, parametrised on addr/data/timestamp/chan widths.
- One sub-module: storage through `bsg_mem_1r1w` (els_p × rec_width, read_write_same_addr_p=0). A write to the slot being read is only legal when rptr also advances, so the head is never read-during-write.
- Channel selection uses `bsg_priority_encode`. The drop increment is a popcount of the remaining qualified bits.

## Test plan
- Single event: ch2 SM, addr=0x100, data=0xAB at timestamp 10, filter=3'b111 -> next cycle rec_v_o=1, rec_o={10, 2, SM, 0x100, 0xAB}, count_o=1.
- Filter: filter=3'b001, channels issue SW then LW -> only the LW is recorded; drop_count_o=0.
- Collision: channels 0, 1 and 3 all qualify in one cycle -> ch0 record stored, drop_count_o=2, overflow_o=1.
- Stop mode, els_p=4: 5 events, no pops -> count_o=4, first four records kept in order, drop_count_o=1.
- Wrap mode, els_p=4: 6 events, no pops -> records 2..5 drained in order, drop_count_o=0, overflow_o=1. Full with simultaneous push+pop -> count_o stays 4, no drop.
- Clear and reset: clear_i while 3 records are held and an event arrives -> empty_o=1 next cycle, event lost, drop_count_o=0. reset_i pulsed mid-drain -> all outputs at reset values asynchronously.
